// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, funct
// codes, ALU control codes and the per-state control word.
package multicycle_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BEQ    = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } stateT;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluOpT;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALUCON_ADD = 3'b010;
    localparam logic [2:0] ALUCON_SUB = 3'b110;
    localparam logic [2:0] ALUCON_AND = 3'b000;
    localparam logic [2:0] ALUCON_OR  = 3'b001;
    localparam logic [2:0] ALUCON_SLT = 3'b111;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       iorD;
        logic       irWrite;
        logic       memWrite;
        logic       regDst;
        logic       memtoReg;
        logic       regWrite;
        logic       aluSrcA;
        logic       pcWrite;
        logic       branch;
        logic [1:0] aluSrcB;
        logic [1:0] pcSrc;
        aluOpT      aluOp;
    } ctrlT;

    // Control word asserted while the FSM sits in state s; unused encodings give all zeros.
    function automatic ctrlT ctrlFor(stateT s);
        ctrlT c;
        c         = '0;
        c.aluSrcB = SRCB_REGB;
        c.pcSrc   = PCSRC_ALU;
        c.aluOp   = ALUOP_ADD;
        case (s)
            FETCH: begin
                c.irWrite = 1'b1;
                c.pcWrite = 1'b1;
                c.aluSrcB = SRCB_FOUR;
            end
            DECODE: c.aluSrcB = SRCB_IMMSH;
            MEMADR: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = SRCB_IMM;
            end
            MEMRD: c.iorD = 1'b1;
            MEMWB: begin
                c.memtoReg = 1'b1;
                c.regWrite = 1'b1;
            end
            MEMWR: begin
                c.iorD     = 1'b1;
                c.memWrite = 1'b1;
            end
            EXEC: begin
                c.aluSrcA = 1'b1;
                c.aluOp   = ALUOP_FUNCT;
            end
            ALUWB: begin
                c.regDst   = 1'b1;
                c.regWrite = 1'b1;
            end
            BEQ: begin
                c.aluSrcA = 1'b1;
                c.aluOp   = ALUOP_SUB;
                c.branch  = 1'b1;
                c.pcSrc   = PCSRC_ALUOUT;
            end
            ADDIEX: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = SRCB_IMM;
            end
            ADDIWB: c.regWrite = 1'b1;
            JUMP: begin
                c.pcWrite = 1'b1;
                c.pcSrc   = PCSRC_JUMP;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALUOp and the instruction funct field to the 3-bit ALU control code.
module alu_decoder
    import multicycle_pkg::*;
(
    input  aluOpT      ALUOp,
    input  logic [5:0] funct,
    output logic [2:0] AluCon
);

    always_comb begin
        AluCon = ALUCON_ADD;
        case (ALUOp)
            ALUOP_SUB: AluCon = ALUCON_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: AluCon = ALUCON_ADD;
                    FUNCT_SUB: AluCon = ALUCON_SUB;
                    FUNCT_AND: AluCon = ALUCON_AND;
                    FUNCT_OR:  AluCon = ALUCON_OR;
                    FUNCT_SLT: AluCon = ALUCON_SLT;
                    default:   AluCon = ALUCON_ADD;
                endcase
            end
            default: AluCon = ALUCON_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle MIPS subset (lw, sw, R-type, beq, addi, j).
module multicycle_controller
    import multicycle_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic [2:0] AluCon,
    output logic [3:0] state
);

    stateT stateReg;
    stateT stateNext;
    ctrlT  ctrlReg;
    ctrlT  ctrlOut;

    always_comb begin
        stateNext = FETCH;
        case (stateReg)
            FETCH: stateNext = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: stateNext = MEMADR;
                    OP_RTYPE:     stateNext = EXEC;
                    OP_BEQ:       stateNext = BEQ;
                    OP_ADDI:      stateNext = ADDIEX;
                    OP_J:         stateNext = JUMP;
                    default:      stateNext = FETCH;
                endcase
            end
            MEMADR: begin
                if (op == OP_LW)
                    stateNext = MEMRD;
                else if (op == OP_SW)
                    stateNext = MEMWR;
                else
                    stateNext = FETCH;
            end
            MEMRD:   stateNext = MEMWB;
            EXEC:    stateNext = ALUWB;
            ADDIEX:  stateNext = ADDIWB;
            default: stateNext = FETCH;
        endcase
    end

    // The control word is registered alongside the state, so it always matches stateReg.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg <= FETCH;
            ctrlReg  <= ctrlFor(FETCH);
        end else begin
            stateReg <= stateNext;
            ctrlReg  <= ctrlFor(stateNext);
        end
    end

    // While reset is held the outputs show FETCH with every write/branch strobe forced low.
    always_comb begin
        ctrlOut = ctrlReg;
        if (reset) begin
            ctrlOut          = ctrlFor(FETCH);
            ctrlOut.irWrite  = 1'b0;
            ctrlOut.memWrite = 1'b0;
            ctrlOut.regWrite = 1'b0;
            ctrlOut.pcWrite  = 1'b0;
            ctrlOut.branch   = 1'b0;
        end
    end

    assign IorD     = ctrlOut.iorD;
    assign IRWrite  = ctrlOut.irWrite;
    assign MemWrite = ctrlOut.memWrite;
    assign RegDst   = ctrlOut.regDst;
    assign MemtoReg = ctrlOut.memtoReg;
    assign RegWrite = ctrlOut.regWrite;
    assign ALUSrcA  = ctrlOut.aluSrcA;
    assign ALUSrcB  = ctrlOut.aluSrcB;
    assign PCSrc    = ctrlOut.pcSrc;
    assign PCEn     = ctrlOut.pcWrite | (ctrlOut.branch & zero);
    assign state    = reset ? FETCH : stateReg;

    alu_decoder u_aluDecoder (
        .ALUOp  (ctrlOut.aluOp),
        .funct  (funct),
        .AluCon (AluCon)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: instruction table with latency/strobe totals,
// directed reset sequences, and random instructions against a path/output model.
module tb_multicycle_controller;

    typedef int intQ[$];

    typedef struct packed {
        logic       iorD;
        logic       irWrite;
        logic       memWrite;
        logic       regDst;
        logic       memtoReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] pcSrc;
        logic       pcEn;
        logic [2:0] aluCon;
        logic [3:0] state;
    } obsT;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         lat;
        int         regWrites;
        int         memWrites;
        int         pcEns;
        logic [2:0] aluCon2;
    } vecT;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] AluCon;
    logic [3:0] state;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .funct    (funct),
        .zero     (zero),
        .IorD     (IorD),
        .IRWrite  (IRWrite),
        .MemWrite (MemWrite),
        .RegDst   (RegDst),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .PCSrc    (PCSrc),
        .PCEn     (PCEn),
        .AluCon   (AluCon),
        .state    (state)
    );

    // Sequence of states each instruction class walks through, starting at FETCH.
    function automatic intQ pathFor(logic [5:0] o);
        intQ p;
        case (o)
            6'b100011: p = {0, 1, 2, 3, 4};
            6'b101011: p = {0, 1, 2, 5};
            6'b000000: p = {0, 1, 6, 7};
            6'b000100: p = {0, 1, 8};
            6'b001000: p = {0, 1, 9, 10};
            6'b000010: p = {0, 1, 11};
            default:   p = {0, 1};
        endcase
        return p;
    endfunction

    function automatic logic [2:0] rtypeAluCon(logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic obsT expectFor(int st, logic [5:0] f, logic z);
        obsT e;
        logic pw, br;
        e        = '0;
        e.aluCon = 3'b010;
        e.state  = st[3:0];
        pw       = 1'b0;
        br       = 1'b0;
        case (st)
            0:  begin e.irWrite = 1'b1; pw = 1'b1; e.aluSrcB = 2'b01; end
            1:  e.aluSrcB = 2'b11;
            2:  begin e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; end
            3:  e.iorD = 1'b1;
            4:  begin e.memtoReg = 1'b1; e.regWrite = 1'b1; end
            5:  begin e.iorD = 1'b1; e.memWrite = 1'b1; end
            6:  begin e.aluSrcA = 1'b1; e.aluCon = rtypeAluCon(f); end
            7:  begin e.regDst = 1'b1; e.regWrite = 1'b1; end
            8:  begin e.aluSrcA = 1'b1; e.aluCon = 3'b110; br = 1'b1; e.pcSrc = 2'b01; end
            9:  begin e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; end
            10: e.regWrite = 1'b1;
            11: begin pw = 1'b1; e.pcSrc = 2'b10; end
            default: ;
        endcase
        e.pcEn = pw | (br & z);
        return e;
    endfunction

    function automatic obsT resetObs();
        obsT e;
        e         = '0;
        e.aluSrcB = 2'b01;
        e.aluCon  = 3'b010;
        return e;
    endfunction

    task automatic check(string nm, obsT exp);
        obsT act;
        act = {IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, PCSrc, PCEn, AluCon, state};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b required %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic checkInt(string nm, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    // Entered just after a falling edge; drive inputs, check, advance one cycle.
    task automatic stepTo(string nm, int st, logic [5:0] o, logic [5:0] f, logic z);
        op    = o;
        funct = f;
        zero  = z;
        #1;
        check(nm, expectFor(st, f, z));
        @(posedge clk);
        @(negedge clk);
    endtask

    // op/funct/zero are randomised in every state that must ignore them.
    task automatic runPath(string nm, logic [5:0] o, logic [5:0] f, logic zb);
        intQ p;
        p = pathFor(o);
        foreach (p[i]) begin
            int st;
            st = p[i];
            stepTo(nm, st,
                   (st == 1 || st == 2) ? o : 6'($urandom()),
                   (st == 6) ? f : 6'($urandom()),
                   (st == 8) ? zb : 1'($urandom()));
        end
    endtask

    task automatic runVec(int idx, vecT v);
        int lat, rw, mw, pe;
        logic [2:0] ac;
        bit done;
        op    = v.op;
        funct = v.funct;
        zero  = v.zero;
        #1;
        lat = 0; rw = 0; mw = 0; pe = 0; ac = 3'b010; done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            rw += int'(RegWrite);
            mw += int'(MemWrite);
            pe += int'(PCEn);
            if (c == 2) ac = AluCon;
            lat++;
            @(posedge clk);
            @(negedge clk);
            if (state == 4'd0) begin
                done = 1'b1;
                break;
            end
        end
        checkInt($sformatf("vec%0d-done", idx), int'(done), 1);
        checkInt($sformatf("vec%0d-latency", idx), lat, v.lat);
        checkInt($sformatf("vec%0d-regWrites", idx), rw, v.regWrites);
        checkInt($sformatf("vec%0d-memWrites", idx), mw, v.memWrites);
        checkInt($sformatf("vec%0d-pcEns", idx), pe, v.pcEns);
        checkInt($sformatf("vec%0d-aluCon", idx), int'(ac), int'(v.aluCon2));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecT vecs[$];
        logic [5:0] fList [5];
        fList = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        vecs.push_back('{6'b100011, 6'b000000, 1'b1, 5, 1, 0, 1, 3'b010});
        vecs.push_back('{6'b101011, 6'b000000, 1'b0, 4, 0, 1, 1, 3'b010});
        vecs.push_back('{6'b000000, 6'b100000, 1'b0, 4, 1, 0, 1, 3'b010});
        vecs.push_back('{6'b000000, 6'b100010, 1'b1, 4, 1, 0, 1, 3'b110});
        vecs.push_back('{6'b000000, 6'b100100, 1'b0, 4, 1, 0, 1, 3'b000});
        vecs.push_back('{6'b000000, 6'b100101, 1'b0, 4, 1, 0, 1, 3'b001});
        vecs.push_back('{6'b000000, 6'b101010, 1'b1, 4, 1, 0, 1, 3'b111});
        vecs.push_back('{6'b000000, 6'b000111, 1'b0, 4, 1, 0, 1, 3'b010});
        vecs.push_back('{6'b000100, 6'b000000, 1'b1, 3, 0, 0, 2, 3'b110});
        vecs.push_back('{6'b000100, 6'b000000, 1'b0, 3, 0, 0, 1, 3'b110});
        vecs.push_back('{6'b001000, 6'b000000, 1'b1, 4, 1, 0, 1, 3'b010});
        vecs.push_back('{6'b000010, 6'b000000, 1'b0, 3, 0, 0, 2, 3'b010});
        vecs.push_back('{6'b111111, 6'b000000, 1'b1, 2, 0, 0, 1, 3'b010});
        vecs.push_back('{6'b000001, 6'b101010, 1'b0, 2, 0, 0, 1, 3'b010});

        reset = 1'b1;
        op    = '0;
        funct = '0;
        zero  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("reset-state", resetObs());
        reset = 1'b0;

        foreach (vecs[i]) runVec(i, vecs[i]);

        // Reset held two cycles while sitting in JUMP.
        stepTo("j-fetch", 0, 6'b000010, 6'b000000, 1'b0);
        stepTo("j-decode", 1, 6'b000010, 6'b000000, 1'b0);
        reset = 1'b1;
        zero  = 1'b1;
        #1;
        check("reset-in-jump", resetObs());
        @(posedge clk);
        @(negedge clk);
        #1;
        check("reset-hold", resetObs());
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        stepTo("post-reset-fetch", 0, 6'b111111, 6'b000000, 1'b1);
        stepTo("post-reset-decode", 1, 6'b111111, 6'b000000, 1'b1);

        // Store aborted by reset in MEMADR.
        stepTo("sw-fetch", 0, 6'b101011, 6'b000000, 1'b0);
        stepTo("sw-decode", 1, 6'b101011, 6'b000000, 1'b0);
        reset = 1'b1;
        #1;
        check("reset-in-memadr", resetObs());
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        stepTo("sw-abort-fetch", 0, 6'b101011, 6'b000000, 1'b0);
        stepTo("sw-abort-decode", 1, 6'b111111, 6'b000000, 1'b0);

        runPath("lw-path", 6'b100011, 6'b000000, 1'b0);
        runPath("slt-path", 6'b000000, 6'b101010, 1'b0);
        runPath("beq-taken", 6'b000100, 6'b000000, 1'b1);
        runPath("beq-not-taken", 6'b000100, 6'b000000, 1'b0);
        runPath("unknown-op", 6'b111111, 6'b000000, 1'b0);

        for (int n = 0; n < 250; n++) begin
            logic [5:0] o, f;
            case ($urandom_range(7, 0))
                0: o = 6'b100011;
                1: o = 6'b101011;
                2: o = 6'b000000;
                3: o = 6'b000100;
                4: o = 6'b001000;
                5: o = 6'b000010;
                default: o = 6'($urandom());
            endcase
            if ($urandom_range(1, 0) == 1)
                f = fList[$urandom_range(4, 0)];
            else
                f = 6'($urandom());
            runPath("random", o, f, 1'($urandom()));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
